// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, ALU-drive and result signals around the shared ALU arbiter.
// The master side is the control unit plus the ALU; the slave side is the arbiter.
interface alu_share_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0;
  logic [2:0]       op0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [2:0]       op1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_sign;
  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic             res_sign;
  logic             res_id;
  logic             res_valid;
  logic             busy;

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1,
    output alu_result, alu_zero, alu_sign,
    input  gnt0, gnt1, alu_op, alu_a, alu_b,
    input  res, res_zero, res_sign, res_id, res_valid, busy
  );

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1,
    input  alu_result, alu_zero, alu_sign,
    output gnt0, gnt1, alu_op, alu_a, alu_b,
    output res, res_zero, res_sign, res_id, res_valid, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter for the single shared ALU: latches the winner's operands,
// captures the ALU flags one cycle later and returns them tagged with the owner ID.
module alu_share_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic             owner, owner_nxt;
  logic             winner;
  logic [2:0]       op_q, op_nxt;
  logic [WIDTH-1:0] a_q, a_nxt, b_q, b_nxt;
  logic [WIDTH-1:0] res_q, res_nxt;
  logic             zero_q, zero_nxt, sign_q, sign_nxt, id_q, id_nxt;
  logic             gnt0_q, gnt0_nxt, gnt1_q, gnt1_nxt;
  logic             valid_q, valid_nxt, busy_q, busy_nxt;

  // Tie-break: fixed priority favours 0, round-robin favours whoever did not win last
  always_comb begin
    if (bus.req0 && bus.req1) winner = FIXED_PRIO ? 1'b0 : ~last_grant;
    else                      winner = bus.req1;
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    owner_nxt      = owner;
    op_nxt         = op_q;
    a_nxt          = a_q;
    b_nxt          = b_q;
    res_nxt        = res_q;
    zero_nxt       = zero_q;
    sign_nxt       = sign_q;
    id_nxt         = id_q;
    gnt0_nxt       = 1'b0;
    gnt1_nxt       = 1'b0;
    valid_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_nxt      = EXEC;
          op_nxt         = winner ? bus.op1 : bus.op0;
          a_nxt          = winner ? bus.a1  : bus.a0;
          b_nxt          = winner ? bus.b1  : bus.b0;
          last_grant_nxt = winner;
          owner_nxt      = winner;
          gnt0_nxt       = ~winner;
          gnt1_nxt       = winner;
        end
      end
      EXEC: begin
        state_nxt = RESP;
        res_nxt   = bus.alu_result;
        zero_nxt  = bus.alu_zero;
        sign_nxt  = bus.alu_sign;
        id_nxt    = owner;
        valid_nxt = 1'b1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_q       <= 3'b000;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      sign_q     <= 1'b0;
      id_q       <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      owner      <= owner_nxt;
      op_q       <= op_nxt;
      a_q        <= a_nxt;
      b_q        <= b_nxt;
      res_q      <= res_nxt;
      zero_q     <= zero_nxt;
      sign_q     <= sign_nxt;
      id_q       <= id_nxt;
      gnt0_q     <= gnt0_nxt;
      gnt1_q     <= gnt1_nxt;
      valid_q    <= valid_nxt;
      busy_q     <= busy_nxt;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.res       = res_q;
  assign bus.res_zero  = zero_q;
  assign bus.res_sign  = sign_q;
  assign bus.res_id    = id_q;
  assign bus.res_valid = valid_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one round-robin and one fixed-priority instance,
// each driving a small behavioural ALU.
module tb_alu_share_arbiter;
  localparam int unsigned W = 32;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_share_arbiter_if #(.WIDTH(W)) if0 ();
  alu_share_arbiter_if #(.WIDTH(W)) if1 ();

  alu_share_arbiter #(.WIDTH(W), .FIXED_PRIO(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  alu_share_arbiter #(.WIDTH(W), .FIXED_PRIO(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'd0:    alu_f = a + b;
      3'd1:    alu_f = a - b;
      3'd2:    alu_f = {31'b0, (a < b)};
      3'd3:    alu_f = {31'b0, ($signed(a) < $signed(b))};
      3'd4:    alu_f = b << a[4:0];
      3'd5:    alu_f = a | b;
      3'd6:    alu_f = a & b;
      default: alu_f = a ^ b;
    endcase
  endfunction

  assign if0.alu_result = alu_f(if0.alu_op, if0.alu_a, if0.alu_b);
  assign if0.alu_zero   = (if0.alu_result == '0);
  assign if0.alu_sign   = if0.alu_result[W-1];
  assign if1.alu_result = alu_f(if1.alu_op, if1.alu_a, if1.alu_b);
  assign if1.alu_zero   = (if1.alu_result == '0);
  assign if1.alu_sign   = if1.alu_result[W-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated op on the round-robin instance; accept edge is the next posedge
  task automatic run_single(input string tag, input logic id, input logic [2:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp_res, input logic exp_zero,
                            input logic exp_sign);
    if (!id) begin if0.req0 = 1'b1; if0.op0 = op; if0.a0 = a; if0.b0 = b; end
    else     begin if0.req1 = 1'b1; if0.op1 = op; if0.a1 = a; if0.b1 = b; end
    step();
    check({tag, "_gnt0"}, 64'(if0.gnt0), 64'(!id));
    check({tag, "_gnt1"}, 64'(if0.gnt1), 64'(id));
    check({tag, "_alu_a"}, 64'(if0.alu_a), 64'(a));
    check({tag, "_alu_op"}, 64'(if0.alu_op), 64'(op));
    check({tag, "_busy"}, 64'(if0.busy), 64'd1);
    if0.req0 = 1'b0;
    if0.req1 = 1'b0;
    step();
    check({tag, "_valid"}, 64'(if0.res_valid), 64'd1);
    check({tag, "_res"}, 64'(if0.res), 64'(exp_res));
    check({tag, "_zero"}, 64'(if0.res_zero), 64'(exp_zero));
    check({tag, "_sign"}, 64'(if0.res_sign), 64'(exp_sign));
    check({tag, "_id"}, 64'(if0.res_id), 64'(id));
    step();
    check({tag, "_valid_drop"}, 64'(if0.res_valid), 64'd0);
    check({tag, "_idle"}, 64'(if0.busy), 64'd0);
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    {if0.req0, if0.req1, if1.req0, if1.req1} = 4'b0;
    {if0.op0, if0.op1, if1.op0, if1.op1}     = '0;
    {if0.a0, if0.b0, if0.a1, if0.b1}         = '0;
    {if1.a0, if1.b0, if1.a1, if1.b1}         = '0;
    step();
    step();
    check("rst_gnt", 64'({if0.gnt0, if0.gnt1, if1.gnt0, if1.gnt1}), 64'd0);
    check("rst_alu", 64'({if0.alu_op, if0.alu_a, if0.alu_b}), 64'd0);
    check("rst_res", 64'({if0.res, if0.res_zero, if0.res_sign, if0.res_id}), 64'd0);
    check("rst_valid_busy", 64'({if0.res_valid, if0.busy, if1.res_valid, if1.busy}), 64'd0);
    rst_n = 1'b1;
    step();

    run_single("add", 1'b0, 3'b000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    run_single("sign", 1'b0, 3'b001, 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_single("zero", 1'b1, 3'b001, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);

    // Round-robin: last winner was 1, so requester 0 goes first
    if0.op0 = 3'b101; if0.a0 = 32'hF0; if0.b0 = 32'h0F;
    if0.op1 = 3'b100; if0.a1 = 32'd4;  if0.b1 = 32'd1;
    if0.req0 = 1'b1;
    if0.req1 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin step(); n++; end while (!(if0.gnt0 || if0.gnt1) && n < 8);
      check("rr_timeout", 64'(n < 8), 64'd1);
      check("rr_overlap", 64'(if0.gnt0 && if0.gnt1), 64'd0);
      check("rr_order", 64'(if0.gnt1), 64'(g % 2));
      if (g == 3) begin if0.req0 = 1'b0; if0.req1 = 1'b0; end
      step();
      check("rr_valid", 64'(if0.res_valid), 64'd1);
      check("rr_res", 64'(if0.res), (g % 2 == 1) ? 64'h10 : 64'hFF);
      check("rr_id", 64'(if0.res_id), 64'(g % 2));
    end
    step();
    check("rr_valid_single", 64'(if0.res_valid), 64'd0);
    step();

    // Fixed priority: requester 0 wins every round while both stay up
    if1.op0 = 3'b110; if1.a0 = 32'hF0; if1.b0 = 32'h3C;
    if1.op1 = 3'b111; if1.a1 = 32'h1;  if1.b1 = 32'h2;
    if1.req0 = 1'b1;
    if1.req1 = 1'b1;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      do begin step(); n++; end while (!(if1.gnt0 || if1.gnt1) && n < 8);
      check("fp_timeout", 64'(n < 8), 64'd1);
      check("fp_gnt0", 64'(if1.gnt0), 64'd1);
      check("fp_gnt1", 64'(if1.gnt1), 64'd0);
      if (g == 2) begin if1.req0 = 1'b0; if1.req1 = 1'b0; end
      step();
      check("fp_res", 64'(if1.res), 64'h30);
      check("fp_id", 64'(if1.res_id), 64'd0);
    end
    step();
    step();

    // Reset during EXEC of a requester-0 op; afterwards a tie must go to 0 again
    if0.req0 = 1'b1; if0.op0 = 3'b000; if0.a0 = 32'd1; if0.b0 = 32'd1;
    step();
    check("mid_gnt", 64'(if0.gnt0), 64'd1);
    if0.req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 64'({if0.gnt0, if0.gnt1}), 64'd0);
    check("mid_rst_alu", 64'({if0.alu_op, if0.alu_a, if0.alu_b}), 64'd0);
    check("mid_rst_res", 64'({if0.res, if0.res_zero, if0.res_sign, if0.res_id}), 64'd0);
    check("mid_rst_busy", 64'(if0.busy), 64'd0);
    step();
    check("mid_rst_valid", 64'(if0.res_valid), 64'd0);
    rst_n = 1'b1;
    if0.op0 = 3'b000; if0.a0 = 32'd2; if0.b0 = 32'd3;
    if0.op1 = 3'b111; if0.a1 = 32'h5; if0.b1 = 32'h6;
    if0.req0 = 1'b1;
    if0.req1 = 1'b1;
    step();
    check("post_rst_gnt0", 64'(if0.gnt0), 64'd1);
    check("post_rst_gnt1", 64'(if0.gnt1), 64'd0);
    if0.req0 = 1'b0;
    if0.req1 = 1'b0;
    step();
    check("post_rst_valid", 64'(if0.res_valid), 64'd1);
    check("post_rst_res", 64'(if0.res), 64'd5);
    check("post_rst_id", 64'(if0.res_id), 64'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
